// File: rtl/adc_capture_ctrl.sv
// ---------------------------------------------------------------------------
// adc_capture_ctrl
//
// Sequencer for the 8-bit ADC front end. It makes the ADC conversion clock
// and enable from a programmable divider and arms on Start. It then waits for
// a trigger and captures a DEPTH-sample burst into an internal buffer. Finally
// it streams the burst out over a valid/ready handshake.
//
// Optional feature macro: ADC_TRIG_TIMEOUT_EN
//   When defined, level-trigger mode forces a trigger after TIMEOUT
//   non-triggering samples and flags Timed_Out. When undefined, ARM waits
//   indefinitely and Timed_Out is tied to 0.
//
// Ports:
//   clk_100MHz  in   system clock (single clock domain)
//   Rst         in   synchronous, active-low reset
//   ADC_Data    in   [7:0] ADC conversion result
//   Start       in   arm request (IDLE only, ignored together with Abort)
//   Abort       in   return to IDLE from any state (highest priority)
//   Div         in   [DIV_W-1:0] sample period in clocks (0/1 act as 2)
//   Trig_Mode   in   0 = free-run, 1 = rising-level trigger
//   Trig_Level  in   [7:0] unsigned trigger threshold
//   clk_ADC     out  ADC conversion clock
//   ADC_En      out  ADC enable (ARM and CAPTURE)
//   Rd_Valid    out  Rd_Data holds a valid buffered sample
//   Rd_Ready    in   consumer accepts the current word
//   Rd_Data     out  [7:0] buffered sample
//   Rd_Last     out  current word is buffer entry DEPTH-1
//   Busy        out  state is not IDLE
//   Done        out  one-cycle pulse after the final readout handshake
//   Timed_Out   out  current or last burst was force-triggered
// ---------------------------------------------------------------------------
module adc_capture_ctrl #(
    parameter int DIV_W   = 16,
    parameter int DEPTH   = 256,
    parameter int AW      = 8,
    parameter int TIMEOUT = 65536
) (
    input  logic             clk_100MHz,
    input  logic             Rst,
    input  logic [7:0]       ADC_Data,
    input  logic             Start,
    input  logic             Abort,
    input  logic [DIV_W-1:0] Div,
    input  logic             Trig_Mode,
    input  logic [7:0]       Trig_Level,
    output logic             clk_ADC,
    output logic             ADC_En,
    output logic             Rd_Valid,
    input  logic             Rd_Ready,
    output logic [7:0]       Rd_Data,
    output logic             Rd_Last,
    output logic             Busy,
    output logic             Done,
    output logic             Timed_Out
);

    typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_CAPTURE, ST_READOUT} state_t;

    state_t           state_q;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;
    logic [DIV_W-1:0] half_div;
    logic [7:0]       level_q;
    logic [7:0]       cur_q;
    logic             prev_vld_q;
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic             clk_adc_q;
    logic             adc_en_q;
    logic             busy_q;
    logic             done_q;
    logic             rd_valid_q;
    logic             rd_last_q;
    logic [7:0]       rd_data_q;
    logic [7:0]       mem [DEPTH];

    logic             sampling;
    logic             strobe;
    logic             level_hit;
    logic             force_trig;
    logic             trig;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic             rd_en;
    logic             rd_fire_last;

    assign sampling = (state_q == ST_ARM) || (state_q == ST_CAPTURE);
    assign half_div = div_q >> 1;
    assign strobe   = sampling && (cnt_q == div_q - DIV_W'(1));
    assign cnt_d    = strobe ? '0 : cnt_q + DIV_W'(1);

    // cur_q still holds the previous sample here; the new one is ADC_Data.
    // A threshold of 255 is defined as never reachable.
    assign level_hit = prev_vld_q && (cur_q < level_q) && (ADC_Data >= level_q)
                       && (level_q != 8'hFF);
    assign trig      = (state_q == ST_ARM) && strobe
                       && (!Trig_Mode || level_hit || force_trig);

    // The trigger sample always lands in entry 0; later samples follow wr_ptr_q.
    assign wr_en   = trig || ((state_q == ST_CAPTURE) && strobe);
    assign wr_addr = (state_q == ST_ARM) ? '0 : wr_ptr_q;

    // Prefetch: fetch when the output register is empty or being consumed.
    assign rd_en        = (state_q == ST_READOUT) && !Abort
                          && (!rd_valid_q || (Rd_Ready && !rd_last_q));
    assign rd_fire_last = rd_valid_q && Rd_Ready && rd_last_q;

`ifdef ADC_TRIG_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tcnt_q;
    logic          timed_out_q;

    assign force_trig = Trig_Mode && (tcnt_q == TW'(TIMEOUT));
    assign Timed_Out  = timed_out_q;

    always_ff @(posedge clk_100MHz) begin
        if (!Rst) begin
            tcnt_q      <= '0;
            timed_out_q <= 1'b0;
        end else if ((state_q == ST_IDLE) && Start && !Abort) begin
            tcnt_q      <= '0;
            timed_out_q <= 1'b0;
        end else if (!Abort && (state_q == ST_ARM) && strobe && Trig_Mode) begin
            if (force_trig) begin
                timed_out_q <= 1'b1;
            end else if (!level_hit) begin
                tcnt_q <= tcnt_q + TW'(1);
            end
        end
    end
`else
    assign force_trig = 1'b0;
    assign Timed_Out  = 1'b0;
`endif

    // Sample buffer with registered read; the read register is the output.
    always_ff @(posedge clk_100MHz) begin
        if (wr_en) begin
            mem[wr_addr] <= ADC_Data;
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (!Rst) begin
            rd_data_q <= '0;
        end else if (rd_en) begin
            rd_data_q <= mem[rd_ptr_q];
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (!Rst) begin
            state_q    <= ST_IDLE;
            div_q      <= DIV_W'(2);
            cnt_q      <= '0;
            level_q    <= '0;
            cur_q      <= '0;
            prev_vld_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            clk_adc_q  <= 1'b0;
            adc_en_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (strobe) begin
                cur_q      <= ADC_Data;
                prev_vld_q <= 1'b1;
            end
            if (Abort) begin
                state_q    <= ST_IDLE;
                cnt_q      <= '0;
                clk_adc_q  <= 1'b0;
                adc_en_q   <= 1'b0;
                busy_q     <= 1'b0;
                rd_valid_q <= 1'b0;
                rd_last_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (Start) begin
                            state_q    <= ST_ARM;
                            div_q      <= (Div < DIV_W'(2)) ? DIV_W'(2) : Div;
                            level_q    <= Trig_Level;
                            cnt_q      <= '0;
                            prev_vld_q <= 1'b0;
                            clk_adc_q  <= 1'b1;
                            adc_en_q   <= 1'b1;
                            busy_q     <= 1'b1;
                        end
                    end
                    ST_ARM, ST_CAPTURE: begin
                        cnt_q     <= cnt_d;
                        clk_adc_q <= (cnt_d < half_div);
                        if (trig) begin
                            state_q  <= ST_CAPTURE;
                            wr_ptr_q <= AW'(1);
                        end else if ((state_q == ST_CAPTURE) && strobe) begin
                            wr_ptr_q <= wr_ptr_q + AW'(1);
                            if (wr_ptr_q == AW'(DEPTH - 1)) begin
                                state_q   <= ST_READOUT;
                                cnt_q     <= '0;
                                clk_adc_q <= 1'b0;
                                adc_en_q  <= 1'b0;
                                rd_ptr_q  <= '0;
                            end
                        end
                    end
                    ST_READOUT: begin
                        if (rd_en) begin
                            rd_valid_q <= 1'b1;
                            rd_last_q  <= (rd_ptr_q == AW'(DEPTH - 1));
                            rd_ptr_q   <= rd_ptr_q + AW'(1);
                        end else if (rd_fire_last) begin
                            state_q    <= ST_IDLE;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                            rd_valid_q <= 1'b0;
                            rd_last_q  <= 1'b0;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign clk_ADC  = clk_adc_q;
    assign ADC_En   = adc_en_q;
    assign Busy     = busy_q;
    assign Done     = done_q;
    assign Rd_Valid = rd_valid_q;
    assign Rd_Last  = rd_last_q;
    assign Rd_Data  = rd_data_q;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Randomized bench for adc_capture_ctrl. The burst contents and timing are
// predicted from the sampling rules (strobe every max(Div,2) cycles, trigger
// selection, DEPTH-sample window) and checked word by word on readout.
module tb_adc_capture_ctrl;

    localparam int DIV_W   = 16;
    localparam int DEPTH   = 256;
    localparam int AW      = 8;
    localparam int TIMEOUT = 16;
`ifdef ADC_TRIG_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic [7:0]       adc_data_i;
    logic             start_i;
    logic             abort_i;
    logic [DIV_W-1:0] div_i;
    logic             trig_mode_i;
    logic [7:0]       trig_level_i;
    logic             clk_adc_o;
    logic             adc_en_o;
    logic             rd_valid_o;
    logic             rd_ready_i;
    logic [7:0]       rd_data_o;
    logic             rd_last_o;
    logic             busy_o;
    logic             done_o;
    logic             timed_out_o;

    int checks = 0;
    int errors = 0;
    logic [7:0] pfx [$];

    adc_capture_ctrl #(
        .DIV_W   (DIV_W),
        .DEPTH   (DEPTH),
        .AW      (AW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk_100MHz (clk),
        .Rst        (rst_n),
        .ADC_Data   (adc_data_i),
        .Start      (start_i),
        .Abort      (abort_i),
        .Div        (div_i),
        .Trig_Mode  (trig_mode_i),
        .Trig_Level (trig_level_i),
        .clk_ADC    (clk_adc_o),
        .ADC_En     (adc_en_o),
        .Rd_Valid   (rd_valid_o),
        .Rd_Ready   (rd_ready_i),
        .Rd_Data    (rd_data_o),
        .Rd_Last    (rd_last_o),
        .Busy       (busy_o),
        .Done       (done_o),
        .Timed_Out  (timed_out_o)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s obs=%0d exp=%0d t=%0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_after_abort(input string tag);
        check_val({tag, "_busy"},     busy_o,     0);
        check_val({tag, "_adc_en"},   adc_en_o,   0);
        check_val({tag, "_clk_adc"},  clk_adc_o,  0);
        check_val({tag, "_rd_valid"}, rd_valid_o, 0);
        check_val({tag, "_rd_last"},  rd_last_o,  0);
        check_val({tag, "_done"},     done_o,     0);
    endtask

    // One Start..Done (or Start..Abort) transaction.
    //   abort_cap    : relative cycle in ARM/CAPTURE to assert Abort (0 = none)
    //   abort_rd     : readout word index at which to assert Abort (-1 = none)
    //   start_glitch : relative cycle to pulse Start while busy (0 = none)
    task automatic run_burst(input int div_in, input bit mode, input int lvl, input bit ramp,
                             input int ready_pct, input int abort_cap, input int abort_rd,
                             input int start_glitch);
        int d;
        int n;
        int k;
        int tcnt;
        int idx;
        bit armed;
        bit prev_ok;
        bit exp_to;
        bit trig;
        bit rdy;
        logic [7:0] prev;
        logic [7:0] s;
        logic [7:0] exp_q [$];

        d = (div_in < 2) ? 2 : div_in;
        k = 0;
        tcnt = 0;
        armed = 1'b1;
        prev_ok = 1'b0;
        exp_to = 1'b0;
        prev = '0;

        start_i      = 1'b1;
        div_i        = DIV_W'(div_in);
        trig_mode_i  = mode;
        trig_level_i = 8'(lvl);
        adc_data_i   = 8'($urandom);
        step();
        start_i = 1'b0;
        n = 1;

        while (exp_q.size() < DEPTH) begin
            check_val("busy_cap",     busy_o,      1);
            check_val("adc_en_cap",   adc_en_o,    1);
            check_val("clk_adc_cap",  clk_adc_o,   ((n - 1) % d) < (d / 2));
            check_val("rd_valid_cap", rd_valid_o,  0);
            check_val("done_cap",     done_o,      0);
            check_val("timed_out",    timed_out_o, exp_to);
            if (n == abort_cap) begin
                abort_i = 1'b1;
                step();
                abort_i = 1'b0;
                check_after_abort("abort_cap");
                $display("burst div=%0d mode=%0d lvl=%0d aborted in capture after %0d strobes",
                         div_in, mode, lvl, k);
                return;
            end
            if (n > 40000) begin
                check_val("capture_bound", exp_q.size(), DEPTH);
                abort_i = 1'b1;
                step();
                abort_i = 1'b0;
                return;
            end
            // Latched inputs are scrambled after Start to prove they are held.
            start_i      = (n == start_glitch);
            div_i        = DIV_W'($urandom_range(0, 9));
            trig_level_i = 8'($urandom);
            if (n % d == 0) begin
                k++;
                if (ramp)                s = 8'(k - 1);
                else if (k <= pfx.size()) s = pfx[k - 1];
                else                     s = 8'($urandom);
                adc_data_i = s;
                if (armed) begin
                    if (!mode) begin
                        trig = 1'b1;
                    end else if (TO_EN && (tcnt == TIMEOUT)) begin
                        trig   = 1'b1;
                        exp_to = 1'b1;
                    end else begin
                        trig = prev_ok && (prev < lvl) && (s >= lvl) && (lvl != 255);
                        if (!trig) tcnt++;
                    end
                    if (trig) begin
                        armed = 1'b0;
                        exp_q.push_back(s);
                    end
                end else begin
                    exp_q.push_back(s);
                end
                prev    = s;
                prev_ok = 1'b1;
            end else begin
                adc_data_i = 8'($urandom);
            end
            step();
            n++;
        end

        // First READOUT cycle: the prefetch is in flight.
        start_i = 1'b0;
        check_val("rd_valid_gap", rd_valid_o, 0);
        check_val("adc_en_rd",    adc_en_o,   0);
        check_val("clk_adc_rd",   clk_adc_o,  0);
        check_val("busy_rd0",     busy_o,     1);
        rd_ready_i = 1'($urandom_range(0, 1));
        step();

        idx = 0;
        forever begin
            check_val("rd_valid",     rd_valid_o,  1);
            check_val("rd_data",      rd_data_o,   exp_q[idx]);
            check_val("rd_last",      rd_last_o,   idx == DEPTH - 1);
            check_val("done_rd",      done_o,      0);
            check_val("busy_rd",      busy_o,      1);
            check_val("timed_out_rd", timed_out_o, exp_to);
            if (idx == abort_rd) begin
                abort_i    = 1'b1;
                rd_ready_i = 1'b1;
                step();
                abort_i    = 1'b0;
                rd_ready_i = 1'b0;
                check_after_abort("abort_rd");
                $display("burst div=%0d mode=%0d lvl=%0d aborted in readout at word %0d",
                         div_in, mode, lvl, idx);
                return;
            end
            rdy = ($urandom_range(0, 99) < ready_pct);
            rd_ready_i = rdy;
            step();
            if (rdy) begin
                if (idx == DEPTH - 1) break;
                idx++;
            end
        end
        rd_ready_i = 1'b0;
        check_val("done_pulse",     done_o,      1);
        check_val("busy_done",      busy_o,      0);
        check_val("rd_valid_done",  rd_valid_o,  0);
        check_val("timed_out_done", timed_out_o, exp_to);
        $display("burst div=%0d mode=%0d lvl=%0d trig_strobe=%0d words=%0d timed_out=%0b",
                 div_in, mode, lvl, k - DEPTH + 1, idx + 1, exp_to);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n        = 1'b0;
        adc_data_i   = '0;
        start_i      = 1'b0;
        abort_i      = 1'b0;
        div_i        = '0;
        trig_mode_i  = 1'b0;
        trig_level_i = '0;
        rd_ready_i   = 1'b0;
        repeat (5) step();
        check_val("rst_clk_adc",   clk_adc_o,   0);
        check_val("rst_adc_en",    adc_en_o,    0);
        check_val("rst_rd_valid",  rd_valid_o,  0);
        check_val("rst_rd_last",   rd_last_o,   0);
        check_val("rst_busy",      busy_o,      0);
        check_val("rst_done",      done_o,      0);
        check_val("rst_timed_out", timed_out_o, 0);
        check_val("rst_rd_data",   rd_data_o,   0);
        rst_n = 1'b1;
        step();

        // Free-run ramp, Div=100.
        run_burst(100, 1'b0, 0, 1'b1, 100, 0, -1, 0);

        // Level trigger on 128: sweep 100 -> 127 -> 128, then 128(first) -> 127 -> 200.
        pfx = '{8'd100, 8'd127, 8'd128};
        run_burst(3, 1'b1, 128, 1'b0, 100, 0, -1, 0);
        pfx = '{8'd128, 8'd127, 8'd200};
        run_burst(2, 1'b1, 128, 1'b0, 100, 0, -1, 0);
        pfx.delete();

        // Random level bursts under random backpressure.
        for (int i = 0; i < 2; i++) begin
            run_burst($urandom_range(2, 5), 1'b1, $urandom_range(1, 254), 1'b0, 50, 0, -1, 0);
        end

        // Abort mid-CAPTURE, then a clean burst.
        run_burst(2, 1'b0, 0, 1'b0, 80, 100, -1, 0);
        run_burst(2, 1'b0, 0, 1'b0, 80, 0, -1, 0);

        // Abort mid-READOUT and on the final word, then a clean burst.
        run_burst(3, 1'b1, $urandom_range(1, 200), 1'b0, 70, 0, 37, 0);
        run_burst(2, 1'b0, 0, 1'b0, 100, 0, DEPTH - 1, 0);
        run_burst(2, 1'b0, 0, 1'b0, 60, 0, -1, 0);

        // Div 0 and 1 behave as 2; Start while capturing is ignored.
        run_burst(0, 1'b0, 0, 1'b0, 100, 0, -1, 50);
        run_burst(1, 1'b0, 0, 1'b0, 100, 0, -1, 0);

        // Start together with Abort in IDLE is ignored.
        start_i = 1'b1;
        abort_i = 1'b1;
        div_i   = DIV_W'(4);
        step();
        start_i = 1'b0;
        abort_i = 1'b0;
        check_val("start_abort_busy",   busy_o,   0);
        check_val("start_abort_adc_en", adc_en_o, 0);
        step();
        check_val("start_abort_busy2",  busy_o,   0);

        // Level 255: forced trigger on strobe TIMEOUT+1 when compiled in,
        // otherwise still armed after 1000 strobes and then aborted.
        run_burst(2, 1'b1, 255, 1'b0, 100, 2001, -1, 0);
        // Next Start clears Timed_Out.
        run_burst(4, 1'b0, 0, 1'b0, 100, 0, -1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
